multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Purpose  : Control FSM for a multicycle 16-bit processor datapath. It walks
//            FETCH -> DECODE -> {EXEC/WB, ADDR/MEMRD/MEMWR/WB, BRANCH, JUMP,
//            HALT} and drives the datapath strobes and selects for each state.
// Ports    : CLK, RST_n (async, active-low)
//            Opcode[3:0]  IR[15:12], sampled only in DECODE
//            MemReady     memory access completes this cycle
//            PCWrite, isBranch, PCSrc[1:0], PCInc, IRWrite     PC / IR control
//            MemRead, MemWrite, RegWrite, ALUSrcB, MemToReg    datapath strobes
//            Halted, Illegal (sticky), State[3:0] (debug)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [3:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       isBranch,
  output logic [1:0] PCSrc,
  output logic       PCInc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcB,
  output logic       MemToReg,
  output logic       Halted,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB     = 4'd3,
    S_ADDR   = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;

  // Next-state logic. The opcode is captured in DECODE so later states are
  // immune to IR changes on the Opcode input.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = Opcode;
        case (Opcode)
          OP_ALU, OP_ADDI:     state_d = S_EXEC;
          OP_LW, OP_SW:        state_d = S_ADDR;
          OP_BEQ:              state_d = S_BRANCH;
          OP_JZ, OP_J, OP_JR:  state_d = S_JUMP;
          OP_HALT:             state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      // Only LW and SW reach ADDR, so anything but LW is a store.
      S_ADDR:   state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_WB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= 4'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode from the registered state. RST_n gates the strobes
  // combinationally so that FETCH's MemRead is suppressed while reset is
  // held, yet appears immediately on release before the first clock edge.
  always_comb begin
    PCWrite  = 1'b0;
    isBranch = 1'b0;
    PCSrc    = 2'd0;
    PCInc    = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrcB  = 1'b0;
    MemToReg = 1'b0;
    Halted   = 1'b0;
    if (RST_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = MemReady;
          PCInc   = MemReady;
        end
        S_EXEC:   ALUSrcB  = (opcode_q == OP_ADDI);
        S_WB: begin
          RegWrite = 1'b1;
          MemToReg = (opcode_q == OP_LW);
        end
        S_ADDR:   ALUSrcB  = 1'b1;
        S_MEMRD:  MemRead  = 1'b1;
        S_MEMWR:  MemWrite = 1'b1;
        S_BRANCH: isBranch = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          case (opcode_q)
            OP_JZ:   PCSrc = 2'd1;
            OP_J:    PCSrc = 2'd2;
            OP_JR:   PCSrc = 2'd3;
            default: PCSrc = 2'd0;
          endcase
        end
        S_HALT:   Halted = 1'b1;
        default:  ;
      endcase
    end
  end

  assign Illegal = illegal_q;
  assign State   = state_q;

endmodule
`default_nettype wire
